// File: rtl/cdb_arbiter_if.sv
// Request, backpressure and broadcast bundle between the execution units,
// the CDB arbiter and the broadcast consumers (ROB completion, reservation stations).
interface cdb_arbiter_if #(
   parameter int SRC_NUM = 3,
   parameter int NICK_W  = 5,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32
);
   logic                      rdy;
   logic                      iclr;
   logic [SRC_NUM-1:0]        iREQ_en;
   logic [SRC_NUM*NICK_W-1:0] iREQ_nick;
   logic [SRC_NUM*DATA_W-1:0] iREQ_dt;
   logic [SRC_NUM-1:0]        iREQ_ac;
   logic [SRC_NUM*ADDR_W-1:0] iREQ_j_pc;
   logic [SRC_NUM-1:0]        oREQ_full;
   logic                      oCDB_en;
   logic [1:0]                oCDB_src;
   logic [NICK_W-1:0]         oCDB_nick;
   logic [DATA_W-1:0]         oCDB_dt;
   logic                      oCDB_ac;
   logic [ADDR_W-1:0]         oCDB_j_pc;

   modport master (
      output rdy, iclr, iREQ_en, iREQ_nick, iREQ_dt, iREQ_ac, iREQ_j_pc,
      input  oREQ_full, oCDB_en, oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc
   );

   modport slave (
      input  rdy, iclr, iREQ_en, iREQ_nick, iREQ_dt, iREQ_ac, iREQ_j_pc,
      output oREQ_full, oCDB_en, oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus scheduler: per-source shallow FIFOs drained one entry per cycle
// by a round-robin arbiter onto a registered write-back broadcast.
module cdb_arbiter #(
   parameter int SRC_NUM = 3,
   parameter int DEPTH   = 2,
   parameter int NICK_W  = 5,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32
) (
   input  logic         clk,
   input  logic         rst,
   cdb_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [NICK_W-1:0] nick;
      logic [DATA_W-1:0] dt;
      logic              ac;
      logic [ADDR_W-1:0] j_pc;
   } entry_t;

   entry_t             mem_r    [SRC_NUM][DEPTH];
   logic [PTR_W-1:0]   rd_ptr_r [SRC_NUM];
   logic [PTR_W-1:0]   wt_ptr_r [SRC_NUM];
   logic [CNT_W-1:0]   count_r  [SRC_NUM];
   logic [1:0]         rr_ptr_r;
   logic               cdb_en_r;
   logic [1:0]         cdb_src_r;
   entry_t             cdb_r;

   entry_t             in_s [SRC_NUM];
   entry_t             head_s;
   logic [SRC_NUM-1:0] push_s;
   logic [SRC_NUM-1:0] pop_s;
   logic [SRC_NUM-1:0] full_s;
   logic [1:0]         grant_s;
   logic               grant_vld_s;
   logic [1:0]         idx_s;
   logic               hit_s;
   logic [1:0]         rr_nxt_s;

   // Unpack the flattened per-source request buses into entries.
   always_comb begin
      for (int i = 0; i < SRC_NUM; i++) begin
         in_s[i].nick = bus.iREQ_nick[i*NICK_W +: NICK_W];
         in_s[i].dt   = bus.iREQ_dt[i*DATA_W +: DATA_W];
         in_s[i].ac   = bus.iREQ_ac[i];
         in_s[i].j_pc = bus.iREQ_j_pc[i*ADDR_W +: ADDR_W];
      end
   end

   // Round-robin grant from start-of-cycle occupancy, plus push/pop qualification.
   always_comb begin
      grant_s     = 2'd0;
      grant_vld_s = 1'b0;
      idx_s       = 2'd0;
      hit_s       = 1'b0;
      for (int k = 0; k < SRC_NUM; k++) begin
         idx_s       = 2'((int'(rr_ptr_r) + k) % SRC_NUM);
         hit_s       = !grant_vld_s && (count_r[idx_s] != {CNT_W{1'b0}});
         grant_s     = hit_s ? idx_s : grant_s;
         grant_vld_s = grant_vld_s || hit_s;
      end
      rr_nxt_s = (grant_s == 2'(SRC_NUM - 1)) ? 2'd0 : grant_s + 2'd1;
      head_s   = mem_r[grant_s][rd_ptr_r[grant_s]];
      for (int i = 0; i < SRC_NUM; i++) begin
         // a full FIFO refuses the push even if it is being popped this cycle
         push_s[i] = bus.iREQ_en[i] && (count_r[i] != CNT_W'(DEPTH))
                     && (in_s[i].nick != {NICK_W{1'b0}});
         pop_s[i]  = grant_vld_s && (grant_s == 2'(i));
         full_s[i] = (count_r[i] == CNT_W'(DEPTH)) || !bus.rdy;
      end
   end

   // FIFO storage, pointers, occupancy and round-robin pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SRC_NUM; i++) begin
            rd_ptr_r[i] <= {PTR_W{1'b0}};
            wt_ptr_r[i] <= {PTR_W{1'b0}};
            count_r[i]  <= {CNT_W{1'b0}};
            for (int d = 0; d < DEPTH; d++) begin
               mem_r[i][d] <= {$bits(entry_t){1'b0}};
            end
         end
         rr_ptr_r <= 2'd0;
      end else if (bus.rdy) begin
         if (bus.iclr) begin
            for (int i = 0; i < SRC_NUM; i++) begin
               rd_ptr_r[i] <= {PTR_W{1'b0}};
               wt_ptr_r[i] <= {PTR_W{1'b0}};
               count_r[i]  <= {CNT_W{1'b0}};
            end
            rr_ptr_r <= 2'd0;
         end else begin
            for (int i = 0; i < SRC_NUM; i++) begin
               if (push_s[i]) begin
                  mem_r[i][wt_ptr_r[i]] <= in_s[i];
                  wt_ptr_r[i]           <= wt_ptr_r[i] + PTR_W'(1);
               end
               if (pop_s[i]) begin
                  rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
               end
               count_r[i] <= count_r[i] + CNT_W'(push_s[i]) - CNT_W'(pop_s[i]);
            end
            if (grant_vld_s) begin
               rr_ptr_r <= rr_nxt_s;
            end
         end
      end
   end

   // Broadcast register: single-cycle valid pulse, payload holds when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cdb_en_r  <= 1'b0;
         cdb_src_r <= 2'd0;
         cdb_r     <= {$bits(entry_t){1'b0}};
      end else if (bus.rdy && !bus.iclr && grant_vld_s) begin
         cdb_en_r  <= 1'b1;
         cdb_src_r <= grant_s;
         cdb_r     <= head_s;
      end else begin
         cdb_en_r  <= 1'b0;
      end
   end

   assign bus.oREQ_full = full_s;
   assign bus.oCDB_en   = cdb_en_r;
   assign bus.oCDB_src  = cdb_src_r;
   assign bus.oCDB_nick = cdb_r.nick;
   assign bus.oCDB_dt   = cdb_r.dt;
   assign bus.oCDB_ac   = cdb_r.ac;
   assign bus.oCDB_j_pc = cdb_r.j_pc;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, async-reset burst, and a
// queue-based reference model scoring a constrained-random run.
module tb_cdb_arbiter;
   localparam int SRC_NUM = 3;
   localparam int DEPTH   = 2;
   localparam int NICK_W  = 5;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int NV      = 29;

   typedef struct packed {
      logic [NICK_W-1:0] nick;
      logic [DATA_W-1:0] dt;
      logic              ac;
      logic [ADDR_W-1:0] j_pc;
   } ent_t;

   typedef struct packed {
      logic       en;
      logic [1:0] src;
      ent_t       e;
   } bc_t;

   typedef struct {
      logic                   rdy;
      logic                   iclr;
      logic [2:0]             en;
      logic [2:0][NICK_W-1:0] nick;
      logic                   x_en;
      logic [1:0]             x_src;
      logic [NICK_W-1:0]      x_nick;
      logic [2:0]             x_full;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   cdb_arbiter_if #(.SRC_NUM(SRC_NUM), .NICK_W(NICK_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   cdb_arbiter #(.SRC_NUM(SRC_NUM), .DEPTH(DEPTH), .NICK_W(NICK_W), .DATA_W(DATA_W),
                 .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   ent_t       mq [SRC_NUM][$];
   logic [1:0] m_rr;
   bc_t        m_out;
   bc_t        exp_q [$];

   function automatic logic [31:0] dt_of(int s, logic [4:0] n);
      return 32'hD000_0000 | (32'(s) << 8) | 32'(n);
   endfunction

   function automatic logic ac_of(int s);
      return (s == 1);
   endfunction

   function automatic logic [31:0] jpc_of(int s, logic [4:0] n);
      return (s == 1) ? (32'h40 + 32'(n)) : 32'h0;
   endfunction

   function automatic vec_t mk(logic r, logic c, logic [2:0] e, int n0, int n1, int n2,
                               logic xe, int xs, int xn, logic [2:0] xf);
      vec_t v;
      v.rdy = r; v.iclr = c; v.en = e;
      v.nick[0] = 5'(n0); v.nick[1] = 5'(n1); v.nick[2] = 5'(n2);
      v.x_en = xe; v.x_src = 2'(xs); v.x_nick = 5'(xn); v.x_full = xf;
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic r, logic c, logic [2:0] e, ent_t [SRC_NUM-1:0] in_v);
      bus.rdy     = r;
      bus.iclr    = c;
      bus.iREQ_en = e;
      for (int s = 0; s < SRC_NUM; s++) begin
         bus.iREQ_nick[s*NICK_W +: NICK_W] = in_v[s].nick;
         bus.iREQ_dt[s*DATA_W +: DATA_W]   = in_v[s].dt;
         bus.iREQ_ac[s]                    = in_v[s].ac;
         bus.iREQ_j_pc[s*ADDR_W +: ADDR_W] = in_v[s].j_pc;
      end
   endtask

   task automatic drive_nicks(logic r, logic c, logic [2:0] e, logic [2:0][NICK_W-1:0] n);
      ent_t [SRC_NUM-1:0] in_v;
      for (int s = 0; s < SRC_NUM; s++) begin
         in_v[s] = '{nick: n[s], dt: dt_of(s, n[s]), ac: ac_of(s), j_pc: jpc_of(s, n[s])};
      end
      drive(r, c, e, in_v);
   endtask

   task automatic model_reset();
      for (int s = 0; s < SRC_NUM; s++) mq[s].delete();
      m_rr  = 2'd0;
      m_out = '0;
      exp_q.delete();
   endtask

   // Reference behaviour for one clock edge; queues the expected broadcast.
   task automatic model_step(logic r, logic c, logic [2:0] e, ent_t [SRC_NUM-1:0] in_v);
      int         g;
      int         idx;
      logic [2:0] acc;
      g = -1;
      m_out.en = 1'b0;
      if (r && c) begin
         for (int s = 0; s < SRC_NUM; s++) mq[s].delete();
         m_rr = 2'd0;
      end else if (r) begin
         for (int s = 0; s < SRC_NUM; s++)
            acc[s] = e[s] && (mq[s].size() < DEPTH) && (in_v[s].nick != 5'd0);
         for (int k = 0; k < SRC_NUM; k++) begin
            idx = (int'(m_rr) + k) % SRC_NUM;
            if (g < 0 && mq[idx].size() > 0) g = idx;
         end
         if (g >= 0) begin
            m_out.en  = 1'b1;
            m_out.src = 2'(g);
            m_out.e   = mq[g].pop_front();
            m_rr      = 2'((g + 1) % SRC_NUM);
         end
         for (int s = 0; s < SRC_NUM; s++) if (acc[s]) mq[s].push_back(in_v[s]);
      end
      exp_q.push_back(m_out);
   endtask

   vec_t               vec [NV];
   ent_t [SRC_NUM-1:0] in_v;
   logic [2:0]         en_v;
   logic [2:0]         mfull;
   logic               rdy_v;
   logic               iclr_v;
   bc_t                got;
   bc_t                want;

   initial begin
      //            rdy iclr en     n0  n1  n2  x_en src nick full
      vec[0]  = mk(1, 0, 3'b001,  3,  0,  0, 0, 0,  0, 3'b000);
      vec[1]  = mk(1, 0, 3'b000,  0,  0,  0, 1, 0,  3, 3'b000);
      vec[2]  = mk(1, 0, 3'b000,  0,  0,  0, 0, 0,  0, 3'b000);
      vec[3]  = mk(1, 1, 3'b000,  0,  0,  0, 0, 0,  0, 3'b000);
      vec[4]  = mk(1, 0, 3'b111,  1,  2,  4, 0, 0,  0, 3'b000);
      vec[5]  = mk(1, 0, 3'b000,  0,  0,  0, 1, 0,  1, 3'b000);
      vec[6]  = mk(1, 0, 3'b000,  0,  0,  0, 1, 1,  2, 3'b000);
      vec[7]  = mk(1, 0, 3'b000,  0,  0,  0, 1, 2,  4, 3'b000);
      vec[8]  = mk(1, 0, 3'b001,  0,  0,  0, 0, 0,  0, 3'b000);
      vec[9]  = mk(1, 0, 3'b111,  5,  6,  7, 0, 0,  0, 3'b000);
      vec[10] = mk(1, 0, 3'b111,  8,  9, 10, 1, 0,  5, 3'b110);
      vec[11] = mk(1, 0, 3'b001, 11,  0,  0, 1, 1,  6, 3'b101);
      vec[12] = mk(1, 0, 3'b010,  0, 12,  0, 1, 2,  7, 3'b011);
      vec[13] = mk(1, 0, 3'b100,  0,  0, 13, 1, 0,  8, 3'b110);
      vec[14] = mk(0, 0, 3'b000,  0,  0,  0, 0, 0,  0, 3'b111);
      vec[15] = mk(0, 0, 3'b000,  0,  0,  0, 0, 0,  0, 3'b111);
      vec[16] = mk(0, 0, 3'b000,  0,  0,  0, 0, 0,  0, 3'b111);
      vec[17] = mk(1, 0, 3'b000,  0,  0,  0, 1, 1,  9, 3'b100);
      vec[18] = mk(1, 0, 3'b000,  0,  0,  0, 1, 2, 10, 3'b000);
      vec[19] = mk(1, 0, 3'b000,  0,  0,  0, 1, 0, 11, 3'b000);
      vec[20] = mk(1, 1, 3'b010,  0, 20,  0, 0, 0,  0, 3'b000);
      vec[21] = mk(1, 0, 3'b000,  0,  0,  0, 0, 0,  0, 3'b000);
      vec[22] = mk(1, 0, 3'b000,  0,  0,  0, 0, 0,  0, 3'b000);
      vec[23] = mk(1, 0, 3'b100,  0,  0, 15, 0, 0,  0, 3'b000);
      vec[24] = mk(1, 0, 3'b000,  0,  0,  0, 1, 2, 15, 3'b000);
      vec[25] = mk(1, 0, 3'b011, 16, 17,  0, 0, 0,  0, 3'b000);
      vec[26] = mk(1, 0, 3'b000,  0,  0,  0, 1, 0, 16, 3'b000);
      vec[27] = mk(1, 0, 3'b000,  0,  0,  0, 1, 1, 17, 3'b000);
      vec[28] = mk(1, 0, 3'b000,  0,  0,  0, 0, 0,  0, 3'b000);

      rst = 1'b0;
      drive_nicks(1'b1, 1'b0, 3'b000, '0);
      #12;
      chk("rst_en",   64'(bus.oCDB_en),   64'(0));
      chk("rst_src",  64'(bus.oCDB_src),  64'(0));
      chk("rst_nick", 64'(bus.oCDB_nick), 64'(0));
      chk("rst_dt",   64'(bus.oCDB_dt),   64'(0));
      chk("rst_ac",   64'(bus.oCDB_ac),   64'(0));
      chk("rst_jpc",  64'(bus.oCDB_j_pc), 64'(0));
      chk("rst_full", 64'(bus.oREQ_full), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;

      for (int r = 0; r < NV; r++) begin
         drive_nicks(vec[r].rdy, vec[r].iclr, vec[r].en, vec[r].nick);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_en", r), 64'(bus.oCDB_en), 64'(vec[r].x_en));
         chk($sformatf("tbl%0d_full", r), 64'(bus.oREQ_full), 64'(vec[r].x_full));
         if (vec[r].x_en) begin
            chk($sformatf("tbl%0d_src", r),  64'(bus.oCDB_src),  64'(vec[r].x_src));
            chk($sformatf("tbl%0d_nick", r), 64'(bus.oCDB_nick), 64'(vec[r].x_nick));
            chk($sformatf("tbl%0d_dt", r),   64'(bus.oCDB_dt),
                64'(dt_of(int'(vec[r].x_src), vec[r].x_nick)));
            chk($sformatf("tbl%0d_ac", r),   64'(bus.oCDB_ac),
                64'(ac_of(int'(vec[r].x_src))));
            chk($sformatf("tbl%0d_jpc", r),  64'(bus.oCDB_j_pc),
                64'(jpc_of(int'(vec[r].x_src), vec[r].x_nick)));
         end
      end

      // Asynchronous reset in the middle of a broadcast burst.
      drive_nicks(1'b1, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1});
      @(posedge clk); #1;
      drive_nicks(1'b1, 1'b0, 3'b000, '0);
      @(posedge clk); #1;
      chk("burst_en", 64'(bus.oCDB_en), 64'(1));
      #2;
      rst = 1'b0;
      #1;
      chk("arst_en",   64'(bus.oCDB_en),   64'(0));
      chk("arst_nick", 64'(bus.oCDB_nick), 64'(0));
      chk("arst_dt",   64'(bus.oCDB_dt),   64'(0));
      chk("arst_full", 64'(bus.oREQ_full), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();

      // Constrained-random traffic scored against the reference model.
      for (int c = 0; c < 600; c++) begin
         rdy_v  = ($urandom_range(0, 9) != 0);
         iclr_v = ($urandom_range(0, 49) == 0);
         for (int s = 0; s < SRC_NUM; s++) begin
            mfull[s] = (mq[s].size() == DEPTH) || !rdy_v;
            en_v[s]  = ($urandom_range(0, 99) < 55) && !mfull[s];
            in_v[s]  = '{nick: 5'($urandom_range(0, 31)), dt: $urandom,
                         ac: (s != 2) && ($urandom_range(0, 1) == 1),
                         j_pc: (s != 2) ? $urandom : 32'h0};
         end
         drive(rdy_v, iclr_v, en_v, in_v);
         @(negedge clk);
         chk("sb_full", 64'(bus.oREQ_full), 64'(mfull));
         model_step(rdy_v, iclr_v, en_v, in_v);
         @(posedge clk); #1;
         got = '{en: bus.oCDB_en, src: bus.oCDB_src,
                 e: '{nick: bus.oCDB_nick, dt: bus.oCDB_dt, ac: bus.oCDB_ac,
                      j_pc: bus.oCDB_j_pc}};
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_queue: got empty expected one entry");
         end else begin
            want = exp_q.pop_front();
            chk("sb_en",   64'(got.en),     64'(want.en));
            chk("sb_src",  64'(got.src),    64'(want.src));
            chk("sb_nick", 64'(got.e.nick), 64'(want.e.nick));
            chk("sb_dt",   64'(got.e.dt),   64'(want.e.dt));
            chk("sb_ac",   64'(got.e.ac),   64'(want.e.ac));
            chk("sb_jpc",  64'(got.e.j_pc), 64'(want.e.j_pc));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
